// File: rtl/frame_buf_pkg.sv
// Shared constants for the frame-buffer blocks.
// The defaults here give a 16-bit word and a 3-bit (8-word) address space.
package frame_buf_pkg;

  localparam int FB_DATA_WIDTH = 16;
  localparam int FB_ADDR_WIDTH = 3;

endpackage : frame_buf_pkg

// File: rtl/data_mem.sv
// Simple dual-port synchronous RAM for frame-buffer data.
// It has one write port and one registered read port; a same-address collision returns the new data.
module data_mem
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic                  collide;
  logic [DATA_WIDTH-1:0] rd_next;

  // The array has no reset so that it stays inferable as block RAM.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign collide = wr_en && rd_en && (wr_addr == rd_addr);
  assign rd_next = collide ? wr_data : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_next;
    end
  end

endmodule : data_mem

// File: tb/tb_data_mem.sv
// Directed testbench for data_mem: it covers reset, readback, read hold, collision,
// the full address range and a reset in the middle of operation.
module tb_data_mem;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;

  int checks   = 0;
  int failures = 0;

  data_mem #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ne(input string tag, input logic [15:0] obs, input logic [15:0] bad);
    checks++;
    assert (obs !== bad) else begin
      failures++;
      $error("FAIL %s observed=%h required_not=%h", tag, obs, bad);
    end
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic read(input logic [2:0] a);
    rd_en = 1'b1; rd_addr = a;
    step();
  endtask

  initial begin
    // The write of 00AA attempted during reset must be suppressed.
    reset = 1'b1; rd_en = 1'b1; rd_addr = 3'd0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h00AA;
    step();
    step();
    check("reset_rd_data", rd_data, 16'h0000);

    reset = 1'b0; wr_en = 1'b0;
    read(3'd0);
    check_ne("reset_write_suppressed", rd_data, 16'h00AA);

    rd_en = 1'b0;
    for (int i = 0; i < 4; i++) write(i[2:0], 16'(i + 1));

    read(3'd0);
    check("readback_a0", rd_data, 16'h0001);
    rd_addr = 3'd1;
    check("read_latency_old_value", rd_data, 16'h0001);
    step();
    check("readback_a1", rd_data, 16'h0002);
    read(3'd2);
    check("readback_a2", rd_data, 16'h0003);

    rd_en = 1'b0; rd_addr = 3'd1;
    step();
    check("read_hold_1", rd_data, 16'h0003);
    step();
    check("read_hold_2", rd_data, 16'h0003);

    read(3'd3);
    check("readback_a3", rd_data, 16'h0004);

    // Reading and writing addr 5 on the same edge must return the new word.
    rd_en = 1'b0;
    write(3'd5, 16'h1111);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h2222;
    rd_en = 1'b1; rd_addr = 3'd5;
    step();
    wr_en = 1'b0;
    check("collision_write_first", rd_data, 16'h2222);
    read(3'd5);
    check("collision_stored", rd_data, 16'h2222);

    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h3333;
    rd_en = 1'b1; rd_addr = 3'd5;
    step();
    wr_en = 1'b0;
    check("simul_diff_addr_read", rd_data, 16'h2222);
    read(3'd6);
    check("simul_diff_addr_write", rd_data, 16'h3333);

    rd_en = 1'b0;
    for (int i = 0; i < 8; i++) write(i[2:0], 16'(i * 16'h0101));
    for (int i = 0; i < 8; i++) begin
      read(i[2:0]);
      check($sformatf("full_range_a%0d", i), rd_data, 16'(i * 16'h0101));
    end
    read(3'd0);
    check("no_alias_a0_a7", rd_data, 16'h0000);

    // A single-cycle reset between writes clears rd_data but leaves the array intact.
    rd_en = 1'b0;
    write(3'd4, 16'hABCD);
    reset = 1'b1; rd_en = 1'b1; rd_addr = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hFFFF;
    step();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check("mid_reset_rd_data", rd_data, 16'h0000);
    write(3'd5, 16'h5A5A);
    for (int i = 0; i < 4; i++) begin
      read(i[2:0]);
      check($sformatf("post_reset_a%0d", i), rd_data, 16'(i * 16'h0101));
    end
    read(3'd4);
    check("post_reset_a4", rd_data, 16'hABCD);
    read(3'd5);
    check("post_reset_a5", rd_data, 16'h5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_data_mem
